// File: rtl/mnist_pixel_loader_pkg.sv
// Shared types and constants for the MNIST pixel loader: FSM states, image geometry, FIFO entry.
package mnist_loader_pkg;

  localparam int PIX_PER_BYTE    = 8;
  localparam int IMG_PIXELS      = 784;
  localparam int FRAME_BYTES_DEF = IMG_PIXELS / PIX_PER_BYTE;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    FLUSH,
    DONE
  } loader_state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } pix_entry_t;

endpackage

// File: rtl/mnist_pixel_loader_fifo.sv
// Small FIFO of {last, data} entries; head is visible combinationally, write on the same edge as push.
// A push into a full FIFO is taken only when a pop happens in the same cycle; otherwise it is ignored.
module loader_fifo
  import mnist_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  pix_entry_t push_dat_i,
  input  logic       pop_i,
  output pix_entry_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  pix_entry_t  mem_q [DEPTH];
  logic        wr_en;
  logic        rd_en;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = wr_en ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = rd_en ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/mnist_pixel_loader.sv
// Host strobe/data receiver framing 98-byte images into a FIFO streamed to the core over valid/ready.
// Byte visible the cycle after its strobe edge (+2 with LOADER_INPUT_SYNC_EN); full FIFO drops and sets overflow.
module mnist_pixel_loader
  import mnist_loader_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int DEPTH       = 4,
  parameter int IDX_W       = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       host_data,
  input  logic             host_stb,
  input  logic             host_sof,
  output logic [7:0]       pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_last,
  output logic             frame_done,
  output logic             overflow,
  output logic             busy,
  output logic [IDX_W-1:0] byte_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  logic       stb_s;
  logic       sof_s;
  logic [7:0] data_s;

`ifdef LOADER_INPUT_SYNC_EN
  logic [9:0] sync1_q;
  logic [9:0] sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {host_stb, host_sof, host_data};
      sync2_q <= sync1_q;
    end
  end

  assign {stb_s, sof_s, data_s} = sync2_q;
`else
  assign stb_s  = host_stb;
  assign sof_s  = host_sof;
  assign data_s = host_data;
`endif

  loader_state_t    state_q;
  logic             stb_prev_q;
  logic [IDX_W-1:0] byte_idx_q;
  logic             overflow_q;
  logic             frame_done_q;
  logic             busy_q;

  logic       wr_evt;
  logic       push;
  logic       push_ok;
  logic       pop;
  logic       full;
  logic       empty;
  pix_entry_t push_entry;
  pix_entry_t head;

  assign wr_evt = stb_s && !stb_prev_q;
  assign pop    = !empty && pix_ready;

  // Only IDLE+sof and any RECV write try to push; FLUSH/DONE writes vanish without overflow.
  always_comb begin
    push            = 1'b0;
    push_entry.data = data_s;
    push_entry.last = (state_q == RECV) && !sof_s && (byte_idx_q == LAST_IDX);
    if (wr_evt) begin
      case (state_q)
        IDLE:    push = sof_s;
        RECV:    push = 1'b1;
        default: push = 1'b0;
      endcase
    end
  end

  assign push_ok = push && (!full || pop);

  loader_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push_ok),
    .push_dat_i(push_entry),
    .pop_i     (pop),
    .head_o    (head),
    .full_o    (full),
    .empty_o   (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      stb_prev_q   <= 1'b0;
      byte_idx_q   <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      stb_prev_q   <= stb_s;
      frame_done_q <= 1'b0;
      if (push && !push_ok) overflow_q <= 1'b1;
      if (push_ok && sof_s) overflow_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (push_ok) begin
            state_q    <= RECV;
            byte_idx_q <= IDX_W'(1);
            busy_q     <= 1'b1;
          end
        end
        RECV: begin
          if (push_ok) begin
            if (sof_s) begin
              byte_idx_q <= IDX_W'(1);
            end else begin
              byte_idx_q <= byte_idx_q + IDX_W'(1);
              if (push_entry.last) state_q <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (pop && head.last) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
            byte_idx_q   <= '0;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pix_valid  = !empty;
  assign pix_data   = empty ? 8'h00 : head.data;
  assign pix_last   = !empty && head.last;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;
  assign byte_idx   = byte_idx_q;

endmodule

// File: tb/tb_mnist_pixel_loader.sv
// Directed plus randomized bench for mnist_pixel_loader against a queue-based transaction model.
module tb_mnist_pixel_loader;
  import mnist_loader_pkg::*;

  localparam int FB    = 98;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] host_data = 8'h00;
  logic       host_stb = 1'b0;
  logic       host_sof = 1'b0;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready = 1'b0;
  logic       pix_last;
  logic       frame_done;
  logic       overflow;
  logic       busy;
  logic [6:0] byte_idx;

  mnist_pixel_loader #(.FRAME_BYTES(FB), .DEPTH(DEPTH), .IDX_W(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .host_data (host_data),
    .host_stb  (host_stb),
    .host_sof  (host_sof),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_last  (pix_last),
    .frame_done(frame_done),
    .overflow  (overflow),
    .busy      (busy),
    .byte_idx  (byte_idx)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: queue of entries still owed to the core plus frame bookkeeping.
  pix_entry_t mq[$];
  int         m_mode = 0;  // 0 waiting for sof, 1 receiving, 2 draining, 3 done pulse
  int         m_idx  = 0;
  bit         m_ovf  = 1'b0;
  bit         m_prev = 1'b0;
  logic [7:0] got[$];
  bit         got_last[$];
  int         done_cnt = 0;

  always @(negedge clk) begin
    int         m0;
    bit         popped_last;
    bit         lastb;
    pix_entry_t e;
    if (rst) begin
      mq.delete();
      m_mode = 0;
      m_idx  = 0;
      m_ovf  = 1'b0;
      m_prev = 1'b0;
    end else begin
      chk("valid", 32'(pix_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("head_data", 32'(pix_data), 32'(mq[0].data));
        chk("head_last", 32'(pix_last), 32'(mq[0].last));
      end
      chk("frame_done", 32'(frame_done), 32'(m_mode == 3));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
      chk("byte_idx", 32'(byte_idx), 32'(m_idx));
      if (frame_done) done_cnt++;
      if (pix_valid && pix_ready) begin
        got.push_back(pix_data);
        got_last.push_back(pix_last);
      end
      // Apply what the coming clock edge does.
      m0 = m_mode;
      popped_last = 1'b0;
      if (pix_ready && mq.size() != 0) begin
        e = mq.pop_front();
        popped_last = e.last;
      end
      if (host_stb && !m_prev && ((m0 == 0 && host_sof) || m0 == 1)) begin
        if (mq.size() < DEPTH) begin
          if (host_sof) begin
            mq.push_back({1'b0, host_data});
            m_idx  = 1;
            m_ovf  = 1'b0;
            m_mode = 1;
          end else begin
            lastb = (m_idx == FB - 1);
            mq.push_back({lastb, host_data});
            m_idx++;
            if (lastb) m_mode = 2;
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_prev = host_stb;
      if (m0 == 3) m_mode = 0;
      else if (m0 == 2 && popped_last) begin
        m_mode = 3;
        m_idx  = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    host_data = d;
    host_sof  = s;
    host_stb  = 1'b1;
    tick();
    host_stb  = 1'b0;
    host_sof  = 1'b0;
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while (mq.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(mq.size()), 32'd0);
    tick();
    tick();
    tick();
  endtask

  initial begin
    int base;
    int dbase;
    int lasts;
    int lastpos;

    repeat (3) tick();
    chk("reset_valid", 32'(pix_valid), 32'd0);
    chk("reset_idx", 32'(byte_idx), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Stray byte without sof while idle.
    send(8'h55, 1'b0);
    tick();
    chk("stray_valid", 32'(pix_valid), 32'd0);
    chk("stray_ovf", 32'(overflow), 32'd0);
    chk("stray_busy", 32'(busy), 32'd0);

    // Full frame, core always ready.
    pix_ready = 1'b1;
    base  = got.size();
    dbase = done_cnt;
    for (int i = 0; i < FB; i++) send(8'(i), i == 0);
    drain();
    chk("frame_count", 32'(got.size() - base), 32'(FB));
    lasts = 0;
    for (int i = 0; i < FB; i++) begin
      chk("frame_byte", 32'(got[base + i]), 32'(i));
      if (got_last[base + i]) lasts++;
    end
    chk("frame_last_cnt", 32'(lasts), 32'd1);
    chk("frame_last_pos", 32'(got_last[base + FB - 1]), 32'd1);
    chk("frame_done_cnt", 32'(done_cnt - dbase), 32'd1);
    chk("frame_idx_end", 32'(byte_idx), 32'd0);
    chk("frame_busy_end", 32'(busy), 32'd0);

    // Backpressure: fifth byte overflows a 4-deep FIFO.
    pix_ready = 1'b0;
    base = got.size();
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), i == 0);
    chk("bp_ovf", 32'(overflow), 32'd1);
    chk("bp_idx", 32'(byte_idx), 32'd4);
    pix_ready = 1'b1;
    drain();
    chk("bp_count", 32'(got.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) chk("bp_byte", 32'(got[base + i]), 32'hA0 + 32'(i));
    chk("bp_ovf_sticky", 32'(overflow), 32'd1);

    // Held strobe yields one push; the sof clears overflow.
    base = got.size();
    send(8'h30, 1'b1);
    chk("held_ovf_clr", 32'(overflow), 32'd0);
    host_data = 8'h31;
    host_stb  = 1'b1;
    repeat (10) tick();
    host_stb = 1'b0;
    tick();
    drain();
    chk("held_idx", 32'(byte_idx), 32'd2);
    chk("held_pushes", 32'(got.size() - base), 32'd2);

    // Mid-frame resync.
    send(8'($urandom), 1'b1);
    for (int i = 0; i < 39; i++) send(8'($urandom), 1'b0);
    chk("resync_pre_idx", 32'(byte_idx), 32'd40);
    drain();
    base  = got.size();
    dbase = done_cnt;
    send(8'h11, 1'b1);
    chk("resync_idx", 32'(byte_idx), 32'd1);
    for (int i = 0; i < FB - 1; i++) send(8'($urandom), 1'b0);
    drain();
    chk("resync_count", 32'(got.size() - base), 32'(FB));
    chk("resync_first", 32'(got[base]), 32'h11);
    lasts = 0;
    lastpos = -1;
    for (int i = base; i < got.size(); i++) if (got_last[i]) begin
      lasts++;
      lastpos = i - base;
    end
    chk("resync_last_cnt", 32'(lasts), 32'd1);
    chk("resync_last_pos", 32'(lastpos), 32'(FB - 1));
    chk("resync_done_cnt", 32'(done_cnt - dbase), 32'd1);

    // Random traffic, checked cycle by cycle by the model.
    for (int i = 0; i < 1500; i++) begin
      host_stb  = 1'($urandom_range(0, 1));
      host_sof  = ($urandom_range(0, 99) == 0);
      host_data = 8'($urandom);
      pix_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    host_stb  = 1'b0;
    host_sof  = 1'b0;
    pix_ready = 1'b0;
    tick();

    // Asynchronous reset while bytes are queued.
    send(8'h40, 1'b1);
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    chk("pre_rst_valid", 32'(pix_valid), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_data", 32'(pix_data), 32'd0);
    chk("rst_last", 32'(pix_last), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idx", 32'(byte_idx), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    pix_ready = 1'b1;
    repeat (5) tick();
    chk("post_rst_valid", 32'(pix_valid), 32'd0);
    send(8'h12, 1'b0);
    chk("post_rst_stray", 32'(pix_valid), 32'd0);
    base = got.size();
    send(8'h77, 1'b1);
    chk("post_rst_sof_pop", 32'(got.size() - base), 32'd1);
    if (got.size() > base) chk("post_rst_sof_byte", 32'(got[base]), 32'h77);
    chk("post_rst_idx", 32'(byte_idx), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
